// File: rtl/ram_program_loader.sv
// Streams a byte block into a single-port synchronous RAM, reads it back, and
// checks the read-back sum before releasing the CPU with cpu_run.
module ram_program_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic [DATA_WIDTH-1:0] checksum,
  output logic                  cpu_run
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_FLUSH = 3'd2;
  localparam logic [2:0] S_VRD   = 3'd3;
  localparam logic [2:0] S_VCMP  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [ADDR_WIDTH:0]   IDX_ONE  = 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] base;
  logic [ADDR_WIDTH:0]   len;
  logic [ADDR_WIDTH:0]   idx;
  logic [DATA_WIDTH-1:0] vsum;

  logic                  handshake;
  logic                  last_idx;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [DATA_WIDTH-1:0] vsum_next;

  assign in_ready  = (state == S_WRITE);
  assign busy      = (state != S_IDLE);
  assign handshake = in_valid && in_ready;
  assign last_idx  = (idx == len - IDX_ONE);
  assign cur_addr  = base + idx[ADDR_WIDTH-1:0];
  assign vsum_next = vsum + ram_rdata;

  // RAM pins are registered, so each state sets up the pins for the next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      base      <= '0;
      len       <= '0;
      idx       <= '0;
      vsum      <= '0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_cs    <= 1'b0;
      ram_we    <= 1'b0;
      ram_oe    <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      err_addr  <= '0;
      checksum  <= '0;
      cpu_run   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            base     <= base_addr;
            len      <= length;
            idx      <= '0;
            vsum     <= '0;
            checksum <= '0;
            error    <= 1'b0;
            err_addr <= '0;
            cpu_run  <= 1'b0;
            if (length == '0) begin
              state   <= S_DONE;
              done    <= 1'b1;
              cpu_run <= 1'b1;
            end else begin
              state <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          if (handshake) begin
            ram_addr  <= cur_addr;
            ram_wdata <= in_data;
            ram_cs    <= 1'b1;
            ram_we    <= 1'b1;
            ram_oe    <= 1'b0;
            checksum  <= checksum + in_data;
            idx       <= idx + IDX_ONE;
            if (last_idx) state <= S_FLUSH;
          end else begin
            ram_cs <= 1'b0;
            ram_we <= 1'b0;
            ram_oe <= 1'b0;
          end
        end
        S_FLUSH: begin
          idx      <= '0;
          ram_addr <= base;
          ram_cs   <= 1'b1;
          ram_we   <= 1'b0;
          ram_oe   <= 1'b1;
          state    <= S_VRD;
        end
        S_VRD: begin
          state <= S_VCMP;
        end
        S_VCMP: begin
          vsum <= vsum_next;
          if (!last_idx) begin
            idx      <= idx + IDX_ONE;
            ram_addr <= cur_addr + ADDR_ONE;
            state    <= S_VRD;
          end else begin
            // Whole-block verdict: the running read-back sum must match the write sum.
            ram_cs  <= 1'b0;
            ram_oe  <= 1'b0;
            done    <= 1'b1;
            error   <= (vsum_next != checksum);
            cpu_run <= (vsum_next == checksum);
            if (vsum_next != checksum) err_addr <= ram_addr;
            state   <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_program_loader.sv
// Directed bench for ram_program_loader with a synchronous RAM model that can
// corrupt one read-back location.
module tb_ram_program_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] base_addr;
  logic [8:0] length;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [7:0] ram_addr;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata;
  logic       ram_cs, ram_we, ram_oe;
  logic       busy, done, error;
  logic [7:0] err_addr;
  logic [7:0] checksum;
  logic       cpu_run;

  int vectors = 0;
  int misses  = 0;

  logic [7:0]  mem [256];
  logic        mem_ready = 1'b0;
  logic        corrupt   = 1'b0;
  int          writes    = 0;
  int          accesses  = 0;
  logic [7:0]  load_bytes [8];
  logic [15:0] vpat;

  ram_program_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .length(length), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe),
    .busy(busy), .done(done), .error(error), .err_addr(err_addr),
    .checksum(checksum), .cpu_run(cpu_run)
  );

  always #5 clk = ~clk;

  // Synchronous RAM model; address 0x02 optionally reads back as 0x00.
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'hEE;
      ram_rdata <= 8'h00;
      mem_ready <= 1'b1;
    end else begin
      if (ram_cs) accesses <= accesses + 1;
      if (ram_cs && ram_we) begin
        mem[ram_addr] <= ram_wdata;
        writes <= writes + 1;
      end else if (ram_cs && ram_oe) begin
        ram_rdata <= (corrupt && ram_addr == 8'h02) ? 8'h00 : mem[ram_addr];
      end
    end
  end

  task automatic do_load(input logic [7:0] b, input logic [8:0] n, input bit use_pat,
                         input bit pulse_busy, output int done_cyc, output int done_cnt,
                         output logic [31:0] we_mask, output int nwr, output int nacc);
    int k;
    int w0;
    int a0;
    bit hs;
    k = 0; done_cyc = -1; done_cnt = 0; we_mask = '0;
    @(negedge clk);
    w0 = writes; a0 = accesses;
    start = 1'b1; base_addr = b; length = n; in_valid = 1'b0;
    @(posedge clk);
    for (int c = 1; c < 120; c++) begin
      @(negedge clk);
      start = pulse_busy && (c == 3);
      base_addr = 8'h80; length = 9'd1;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (ram_cs && ram_we && c < 32) we_mask[c] = 1'b1;
      if (done_cyc >= 0 && c > done_cyc) break;
      in_valid = (k < int'(n)) && (!use_pat || c > 16 || vpat[c-1]);
      in_data  = (k < 8) ? load_bytes[k] : 8'h00;
      hs = in_valid && in_ready;
      @(posedge clk);
      if (hs) k++;
    end
    in_valid = 1'b0; start = 1'b0;
    nwr = writes - w0;
    nacc = accesses - a0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; in_valid = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({ram_cs, ram_we, ram_oe, busy, done, error, cpu_run, in_ready} !== 8'h00 ||
        ram_addr !== 8'h00 || checksum !== 8'h00 || err_addr !== 8'h00) begin
      misses++;
      $display("FAIL reset_outputs got cs%b we%b oe%b busy%b done%b err%b run%b rdy%b addr%h sum%h", ram_cs, ram_we, ram_oe, busy, done, error, cpu_run, in_ready, ram_addr, checksum);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int dc, dn, nw, na; logic [31:0] wm;
    load_bytes = '{8'h10, 8'h1C, 8'h30, 8'h1D, 8'h00, 8'h00, 8'h00, 8'h00};
    do_load(8'h00, 9'd4, 1'b0, 1'b0, dc, dn, wm, nw, na);
    vectors++; if (dc !== 14) begin misses++; $display("FAIL basic_done_cycle got %0d want 14", dc); end
    vectors++; if (checksum !== 8'h79) begin misses++; $display("FAIL basic_checksum got %h want 79", checksum); end
    vectors++; if ({mem[0], mem[1], mem[2], mem[3]} !== 32'h101C301D) begin misses++; $display("FAIL basic_ram got %h%h%h%h want 101C301D", mem[0], mem[1], mem[2], mem[3]); end
    vectors++; if (error !== 1'b0 || cpu_run !== 1'b1) begin misses++; $display("FAIL basic_status got err%b run%b want err0 run1", error, cpu_run); end
    vectors++; if (wm !== 32'h3C) begin misses++; $display("FAIL basic_we_cycles got %h want 3c", wm); end
    vectors++; if (busy !== 1'b0 || dn !== 1) begin misses++; $display("FAIL basic_end got busy%b done_count%0d want busy0 done_count1", busy, dn); end
  endtask

  task automatic test_wrap();
    int dc, dn, nw, na; logic [31:0] wm;
    load_bytes = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00, 8'h00, 8'h00, 8'h00};
    do_load(8'hFE, 9'd4, 1'b0, 1'b0, dc, dn, wm, nw, na);
    vectors++; if ({mem[254], mem[255], mem[0], mem[1]} !== 32'hAABBCCDD) begin misses++; $display("FAIL wrap_ram got %h%h%h%h want AABBCCDD", mem[254], mem[255], mem[0], mem[1]); end
    vectors++; if (checksum !== 8'h0E) begin misses++; $display("FAIL wrap_checksum got %h want 0e", checksum); end
    vectors++; if (cpu_run !== 1'b1 || dc !== 14) begin misses++; $display("FAIL wrap_status got run%b done_cycle%0d want run1 done_cycle14", cpu_run, dc); end
  endtask

  task automatic test_mismatch();
    int dc, dn, nw, na; logic [31:0] wm;
    load_bytes = '{8'h10, 8'h1C, 8'h30, 8'h1D, 8'h00, 8'h00, 8'h00, 8'h00};
    corrupt = 1'b1;
    do_load(8'h00, 9'd4, 1'b0, 1'b0, dc, dn, wm, nw, na);
    corrupt = 1'b0;
    vectors++; if (error !== 1'b1) begin misses++; $display("FAIL mismatch_error got %b want 1", error); end
    vectors++; if (cpu_run !== 1'b0) begin misses++; $display("FAIL mismatch_cpu_run got %b want 0", cpu_run); end
    vectors++; if (dn !== 1 || dc !== 14) begin misses++; $display("FAIL mismatch_done got count%0d cycle%0d want count1 cycle14", dn, dc); end
  endtask

  task automatic test_zero_length();
    int dc, dn, nw, na; logic [31:0] wm;
    do_load(8'h40, 9'd0, 1'b0, 1'b0, dc, dn, wm, nw, na);
    vectors++; if (dc !== 1) begin misses++; $display("FAIL zero_done_cycle got %0d want 1", dc); end
    vectors++; if (na !== 0) begin misses++; $display("FAIL zero_ram_access got %0d want 0", na); end
    vectors++; if (checksum !== 8'h00 || cpu_run !== 1'b1 || error !== 1'b0) begin misses++; $display("FAIL zero_status got sum%h run%b err%b want sum00 run1 err0", checksum, cpu_run, error); end
  endtask

  task automatic test_valid_toggle();
    int dc, dn, nw, na; logic [31:0] wm;
    load_bytes = '{8'h10, 8'h1C, 8'h30, 8'h1D, 8'h00, 8'h00, 8'h00, 8'h00};
    vpat = 16'b0000_0000_0101_1001;
    do_load(8'h00, 9'd4, 1'b1, 1'b0, dc, dn, wm, nw, na);
    vectors++; if (nw !== 4) begin misses++; $display("FAIL toggle_write_count got %0d want 4", nw); end
    vectors++; if (wm !== 32'h164) begin misses++; $display("FAIL toggle_we_cycles got %h want 164", wm); end
    vectors++; if (dc !== 17 || checksum !== 8'h79 || cpu_run !== 1'b1) begin misses++; $display("FAIL toggle_result got cycle%0d sum%h run%b want cycle17 sum79 run1", dc, checksum, cpu_run); end
  endtask

  task automatic test_reset_midload();
    int dc, dn, nw, na; logic [31:0] wm;
    load_bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    @(negedge clk); start = 1'b1; base_addr = 8'h20; length = 9'd8;
    @(posedge clk);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk); start = 1'b0; in_valid = 1'b1; in_data = load_bytes[c-1];
      @(posedge clk);
    end
    @(negedge clk); in_valid = 1'b0; rst_n = 1'b0;
    #1;
    vectors++;
    if ({ram_cs, ram_we, ram_oe, busy, done, error, cpu_run, in_ready} !== 8'h00 ||
        ram_addr !== 8'h00 || ram_wdata !== 8'h00 || checksum !== 8'h00) begin
      misses++;
      $display("FAIL midreset_outputs got cs%b we%b oe%b busy%b done%b err%b run%b rdy%b addr%h sum%h", ram_cs, ram_we, ram_oe, busy, done, error, cpu_run, in_ready, ram_addr, checksum);
    end
    @(negedge clk); rst_n = 1'b1;
    vectors++; if (mem[8'h21] !== 8'h02) begin misses++; $display("FAIL midreset_kept_ram got %h want 02", mem[8'h21]); end
    load_bytes = '{8'h5A, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    do_load(8'h10, 9'd2, 1'b0, 1'b1, dc, dn, wm, nw, na);
    vectors++; if (dc !== 8) begin misses++; $display("FAIL restart_done_cycle got %0d want 8", dc); end
    vectors++; if (checksum !== 8'h8D || cpu_run !== 1'b1) begin misses++; $display("FAIL restart_status got sum%h run%b want sum8d run1", checksum, cpu_run); end
    vectors++; if ({mem[8'h10], mem[8'h11]} !== 16'h5A33 || mem[8'h80] !== 8'hEE) begin misses++; $display("FAIL restart_ram got %h%h m80=%h want 5A33 m80=EE", mem[8'h10], mem[8'h11], mem[8'h80]); end
    vectors++; if (nw !== 2 || dn !== 1) begin misses++; $display("FAIL busy_start_ignored got writes%0d dones%0d want 2 1", nw, dn); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_mismatch();
    test_zero_length();
    test_valid_toggle();
    test_reset_midload();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule
